dm633_refresh: RTL



---
 rtl/dm633_refresh_if.sv | 28 ++
 rtl/dm633_refresh.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dm633_refresh_if.sv
// Bundles the refresh engine's request handshake, frame buffer read port and
// DM633 serial pins so they travel together between the engine and its users.
interface dm633_refresh_if #(
  parameter int c_addr_w = 10,
  parameter int c_bps    = 12
);
  logic                i_start;
  logic                o_busy;
  logic                o_done;
  logic                o_ren;
  logic [c_addr_w-1:0] o_raddr;
  logic [c_bps-1:0]    i_rdata;
  logic                o_dck;
  logic                o_dai;
  logic                o_lat;

  // The refresh engine itself.
  modport slave (
    input  i_start, i_rdata,
    output o_busy, o_done, o_ren, o_raddr, o_dck, o_dai, o_lat
  );

  // Whoever requests refreshes and serves the frame buffer reads.
  modport master (
    output i_start, i_rdata,
    input  o_busy, o_done, o_ren, o_raddr, o_dck, o_dai, o_lat
  );
endinterface

// File: rtl/dm633_refresh.sv
// Streams one frame from the frame buffer onto the DM633 chain, last channel
// first, MSB first, then pulses LAT. Every output is a register.
module dm633_refresh #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bps       = 12,
  parameter int c_clkdiv    = 4,
  parameter int c_lat_w     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  dm633_refresh_if.slave   bus
);

  localparam int c_div_w = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
  localparam int c_bit_w = (c_bps > 1) ? $clog2(c_bps) : 1;
  localparam int c_lcn_w = $clog2(c_lat_w + 1);

  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);
  localparam logic [c_addr_w-1:0] c_addr_one  = c_addr_w'(1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_clkdiv - 1);
  localparam logic [c_div_w-1:0]  c_div_one   = c_div_w'(1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_bps - 1);
  localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
  localparam logic [c_lcn_w-1:0]  c_lat_last  = c_lcn_w'(c_lat_w);
  localparam logic [c_lcn_w-1:0]  c_lat_one   = c_lcn_w'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH, S_DONE
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [c_addr_w-1:0] r_addr,    w_addr_nxt;
  logic [c_bps-1:0]    r_shift,   w_shift_nxt;
  logic [c_bit_w-1:0]  r_bit_cnt, w_bit_nxt;
  logic [c_div_w-1:0]  r_div_cnt, w_div_nxt;
  logic [c_lcn_w-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_ren,     w_ren_nxt;
  logic                r_dck,     w_dck_nxt;
  logic                r_dai,     w_dai_nxt;
  logic                r_lat,     w_lat_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= c_addr_last;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_lat_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ren     <= 1'b0;
      r_dck     <= 1'b0;
      r_dai     <= 1'b0;
      r_lat     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_div_cnt <= w_div_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ren     <= w_ren_nxt;
      r_dck     <= w_dck_nxt;
      r_dai     <= w_dai_nxt;
      r_lat     <= w_lat_nxt;
    end
  end

  // Next-state logic computes the output values for the coming state, so the
  // registered outputs line up cycle-for-cycle with r_state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit_cnt;
    w_div_nxt     = r_div_cnt;
    w_lat_cnt_nxt = r_lat_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_ren_nxt     = 1'b0;
    w_dck_nxt     = r_dck;
    w_dai_nxt     = r_dai;
    w_lat_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = c_addr_last;
          w_ren_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_SHIFT;
        w_shift_nxt = bus.i_rdata;
        w_dai_nxt   = bus.i_rdata[c_bps-1];
        w_dck_nxt   = 1'b0;
        w_bit_nxt   = '0;
        w_div_nxt   = '0;
      end
      S_SHIFT: begin
        if (r_div_cnt != c_div_last) begin
          w_div_nxt = r_div_cnt + c_div_one;
        end else begin
          w_div_nxt = '0;
          if (!r_dck) begin
            w_dck_nxt = 1'b1;
          end else begin
            w_dck_nxt = 1'b0;
            if (r_bit_cnt != c_bit_last) begin
              w_bit_nxt   = r_bit_cnt + c_bit_one;
              w_shift_nxt = r_shift << 1;
              w_dai_nxt   = r_shift[c_bps-2];
            end else begin
              w_dai_nxt = 1'b0;
              if (r_addr != '0) begin
                w_addr_nxt  = r_addr - c_addr_one;
                w_state_nxt = S_FETCH;
                w_ren_nxt   = 1'b1;
              end else begin
                w_state_nxt   = S_LATCH;
                w_lat_cnt_nxt = '0;
              end
            end
          end
        end
      end
      S_LATCH: begin
        // First LATCH cycle is a guard with LAT low after the last DCK high.
        if (r_lat_cnt != c_lat_last) begin
          w_lat_cnt_nxt = r_lat_cnt + c_lat_one;
          w_lat_nxt     = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_addr_nxt  = c_addr_last;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_ren   = r_ren;
  assign bus.o_raddr = r_addr;
  assign bus.o_dck   = r_dck;
  assign bus.o_dai   = r_dai;
  assign bus.o_lat   = r_lat;

endmodule
